// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Purpose  : Buffered byte source for a UART transmit byte interface.
//             Producers push bytes into a circular FIFO at full clock rate;
//             a three-state FSM drains it one byte at a time, holding the
//             transmit request until the UART reports busy, then waiting for
//             the UART to go idle before issuing the next byte.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous active-low reset
//             wr_en      - push wr_data this cycle
//             wr_data    - byte to transmit
//             full       - FIFO holds DEPTH bytes
//             empty      - FIFO holds no bytes
//             level      - bytes stored (byte in flight excluded)
//             overflow   - 1-cycle pulse: push dropped because FIFO full
//             idata      - byte presented to the UART
//             newTxData  - transmit request, held until UART raises txBusy
//             txBusy     - UART busy-transmitting flag
//             sent       - 1-cycle pulse: UART finished a byte
//             stall      - sticky: request outstanding for ACK_TIMEOUT cycles
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    idata,
    output logic          newTxData,
    input  logic          txBusy,
    output logic          sent,
    output logic          stall
);

    localparam int            CW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] c_timeout = CW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_level, w_level_nxt;
    logic            r_full, r_empty, r_overflow;

    logic [7:0]      r_idata, w_idata_nxt;
    logic            r_new, w_new_nxt;
    logic            r_sent, w_sent_nxt;
    logic            r_stall, w_stall_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            w_pop;
    logic            w_push;

    // ------------------------------------------------------------------
    // FSM next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idata_nxt = r_idata;
        w_new_nxt   = r_new;
        w_sent_nxt  = 1'b0;
        w_stall_nxt = r_stall;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A busy UART here means someone else is transmitting: hold off.
                if (!r_empty && !txBusy) begin
                    w_pop       = 1'b1;
                    w_idata_nxt = r_mem[r_rd_ptr];
                    w_new_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The request is never withdrawn; the UART only accepts when
                // its line is idle, so we just keep asking.
                w_new_nxt = 1'b1;
                if (txBusy) begin
                    w_new_nxt   = 1'b0;
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt != c_timeout) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_cnt_nxt == c_timeout) begin
                        w_stall_nxt = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!txBusy) begin
                    w_sent_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A push into a full FIFO still fits when the head leaves this same cycle.
    assign w_push = wr_en && (!r_full || w_pop);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + (AW+1)'(1);
            2'b01:   w_level_nxt = r_level - (AW+1)'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array (no reset needed: contents are qualified by level)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // State, pointers, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_idata    <= 8'h00;
            r_new      <= 1'b0;
            r_sent     <= 1'b0;
            r_stall    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idata    <= w_idata_nxt;
            r_new      <= w_new_nxt;
            r_sent     <= w_sent_nxt;
            r_stall    <= w_stall_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == c_depth);
            r_empty    <= (w_level_nxt == '0);
            r_overflow <= wr_en && r_full && !w_pop;
        end
    end

    assign full      = r_full;
    assign empty     = r_empty;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign idata     = r_idata;
    assign newTxData = r_new;
    assign sent      = r_sent;
    assign stall     = r_stall;

endmodule
`default_nettype wire
